// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter.
// FSM state encoding and latched memory-op encoding; no ports.
package mem_arbiter_pkg;

    localparam int unsigned AddrW = 16;
    localparam int unsigned DataW = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2
    } state_e;

    typedef enum logic {
        OpRd = 1'b0,
        OpWr = 1'b1
    } op_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant/priority logic with the I-port starvation counter.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   arb_en_i                : arbitration allowed this cycle (FSM idle, not in reset)
//   i_req_i, d_req_i        : fetch request, well-formed data request
//   grant_i_o, grant_d_o    : one-hot (or zero) grant, combinational
module mem_arb_grant #(
    parameter int unsigned StarveLimit = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic arb_en_i,
    input  logic i_req_i,
    input  logic d_req_i,
    output logic grant_i_o,
    output logic grant_d_o
);

    localparam int unsigned CntW = $clog2(StarveLimit + 1);

    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
    logic            at_limit;

    assign at_limit  = (starve_cnt_q == CntW'(StarveLimit));
    // D-port has priority unless the I-port has lost StarveLimit times in a row.
    assign grant_i_o = arb_en_i & i_req_i & (~d_req_i | at_limit);
    assign grant_d_o = arb_en_i & d_req_i & ~grant_i_o;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req_i || grant_i_o) begin
            starve_cnt_d = '0;
        end else if (grant_d_o && !at_limit) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem_system between the fetch (read-only I) port and the data (R/W D) port.
// One transaction outstanding at a time; hits complete in the issue cycle.
// Ports:
//   clk_i, rst_i                         : clock, synchronous active-high reset
//   i_rd_i, i_addr_i                     : fetch request
//   i_rdata_o, i_done_o, i_stall_o, i_err_o : fetch response
//   d_rd_i, d_wr_i, d_addr_i, d_wdata_i  : data request
//   d_rdata_o, d_done_o, d_stall_o, d_err_o : data response
//   createdump_i / m_createdump_o        : passthrough
//   m_rd_o, m_wr_o, m_addr_o, m_wdata_o  : memory request
//   m_rdata_i, m_done_i, m_stall_i, m_err_i : memory response
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned StarveLimit = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_rd_i,
    input  logic [AddrW-1:0] i_addr_i,
    output logic [DataW-1:0] i_rdata_o,
    output logic             i_done_o,
    output logic             i_stall_o,
    output logic             i_err_o,
    input  logic             d_rd_i,
    input  logic             d_wr_i,
    input  logic [AddrW-1:0] d_addr_i,
    input  logic [DataW-1:0] d_wdata_i,
    output logic [DataW-1:0] d_rdata_o,
    output logic             d_done_o,
    output logic             d_stall_o,
    output logic             d_err_o,
    input  logic             createdump_i,
    output logic             m_rd_o,
    output logic             m_wr_o,
    output logic [AddrW-1:0] m_addr_o,
    output logic [DataW-1:0] m_wdata_o,
    input  logic [DataW-1:0] m_rdata_i,
    input  logic             m_done_i,
    input  logic             m_stall_i,
    input  logic             m_err_i,
    output logic             m_createdump_o
);

    state_e           state_q, state_d;
    logic [AddrW-1:0] addr_q, addr_d;
    logic [DataW-1:0] wdata_q, wdata_d;
    op_e              op_q, op_d;

    logic grant_i, grant_d;
    logic d_valid, d_proto_err, d_holds;
    logic unused_m_stall;

    // m_done is authoritative for sequencing.
    assign unused_m_stall = m_stall_i;
    assign m_createdump_o = createdump_i;

    assign d_valid     = d_rd_i ^ d_wr_i;
    assign d_proto_err = d_rd_i & d_wr_i & (state_q != StBusyD) & ~rst_i;
    // Owner counts as still requesting only if it holds the op it was granted.
    assign d_holds     = (op_q == OpWr) ? d_wr_i : d_rd_i;

    mem_arb_grant #(
        .StarveLimit(StarveLimit)
    ) u_grant (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .arb_en_i ((state_q == StIdle) & ~rst_i),
        .i_req_i  (i_rd_i),
        .d_req_i  (d_valid),
        .grant_i_o(grant_i),
        .grant_d_o(grant_d)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_d      = op_q;
        m_rd_o    = 1'b0;
        m_wr_o    = 1'b0;
        m_addr_o  = addr_q;
        m_wdata_o = wdata_q;
        i_done_o  = 1'b0;
        i_err_o   = 1'b0;
        i_rdata_o = '0;
        d_done_o  = 1'b0;
        d_err_o   = 1'b0;
        d_rdata_o = '0;

        if (rst_i) begin
            m_addr_o  = '0;
            m_wdata_o = '0;
        end else begin
            if (d_proto_err) begin
                d_done_o = 1'b1;
                d_err_o  = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (grant_i) begin
                        m_rd_o    = 1'b1;
                        m_addr_o  = i_addr_i;
                        m_wdata_o = '0;
                        addr_d    = i_addr_i;
                        wdata_d   = '0;
                        op_d      = OpRd;
                        if (m_done_i) begin
                            i_done_o  = 1'b1;
                            i_rdata_o = m_rdata_i;
                            i_err_o   = m_err_i;
                        end else begin
                            state_d = StBusyI;
                        end
                    end else if (grant_d) begin
                        m_rd_o    = d_rd_i;
                        m_wr_o    = d_wr_i;
                        m_addr_o  = d_addr_i;
                        m_wdata_o = d_wdata_i;
                        addr_d    = d_addr_i;
                        wdata_d   = d_wdata_i;
                        op_d      = d_wr_i ? OpWr : OpRd;
                        if (m_done_i) begin
                            d_done_o  = 1'b1;
                            d_rdata_o = m_rdata_i;
                            d_err_o   = m_err_i;
                        end else begin
                            state_d = StBusyD;
                        end
                    end
                end
                StBusyI: begin
                    if (m_done_i) begin
                        state_d = StIdle;
                        // A flushed fetch completes silently.
                        if (i_rd_i) begin
                            i_done_o  = 1'b1;
                            i_rdata_o = m_rdata_i;
                            i_err_o   = m_err_i;
                        end
                    end
                end
                StBusyD: begin
                    if (m_done_i) begin
                        state_d = StIdle;
                        if (d_holds) begin
                            d_done_o  = 1'b1;
                            d_rdata_o = m_rdata_i;
                            d_err_o   = m_err_i;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        i_stall_o = i_rd_i & ~i_done_o & ~rst_i;
        d_stall_o = (d_rd_i | d_wr_i) & ~d_done_o & ~rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OpRd;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
        end
    end

endmodule
